// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// Shift-add multiplier and restoring divider, one bit per cycle.
module mdu_seq #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic               dbz_out_q, dbz_out_d;

    logic               sgn;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign sgn    = ~op[0];
    assign rs_abs = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign rt_abs = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // Multiply: add multiplicand when multiplier LSB set, then shift right
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, a_q} : '0);

    // Divide: remainder shifted left with next dividend bit appended
    assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_ge = rem_sh >= {1'b0, a_q};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                         : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        3'd4: hi_d = rs_data;
                        3'd5: lo_d = rs_data;
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d  = RUN;
                            cnt_d    = CNT_W'(WIDTH);
                            is_div_d = op[1];
                            neg_d    = sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                            rneg_d   = sgn & rs_data[WIDTH-1];
                            dbz_d    = op[1] && (rt_data == '0);
                            if (op[1]) begin
                                a_d   = rt_abs;
                                acc_d = {{WIDTH{1'b0}}, rs_abs};
                            end else begin
                                a_d   = rs_abs;
                                acc_d = {{WIDTH{1'b0}}, rt_abs};
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = FIX;
                    if (is_div_q) begin
                        if (rem_ge) begin
                            acc_d = {rem_sh[WIDTH-1:0] - a_q,
                                     acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {rem_sh[WIDTH-1:0],
                                     acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d    = 1'b1;
                    dbz_out_d = dbz_q;
                    if (is_div_q) begin
                        hi_d = rem;
                        lo_d = dbz_q ? '1 : quo;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed and random MULT/DIV/MTHI/MTLO
// checked against an arithmetic reference model.
module tb_mdu_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_seq #(.WIDTH(32)) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .op(op),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .flush(flush),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .hi(hi),
        .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {hi,lo} expected from plain arithmetic on the operands
    function automatic logic [63:0] model(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sp;
        int     sa;
        int     sb;
        logic [63:0] r;
        sa = int'(a);
        sb = int'(b);
        r  = '0;
        case (o)
            3'd0: begin
                sp = longint'(sa) * longint'(sb);
                r  = 64'(sp);
            end
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0)
                    r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else
                    r = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
            default: r = {exp_hi, exp_lo};
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] e;
        logic        e_dbz;
        int          n;
        e     = model(o, a, b);
        e_dbz = o[1] && (b == 0);
        @(negedge CLK);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge CLK);
        start = 1'b0;
        op = 3'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 5) begin
                check("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
                check("no_early_done", {63'd0, done}, 64'd0);
            end
            n++;
            @(negedge CLK);
        end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        check("busy_len", 64'(n), 64'd33);
        check("done", {63'd0, done}, 64'd1);
        check("dbz", {63'd0, div_by_zero}, {63'd0, e_dbz});
        check("hilo", {hi, lo}, e);
        @(negedge CLK);
        check("pulse_end", {62'd0, done, div_by_zero}, 64'd0);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;
        logic        saw_done;
        int          n;

        repeat (3) @(negedge CLK);
        check("rst_out", {busy, done, div_by_zero, hi, lo}, '0);
        RST = 1'b1;
        @(negedge CLK);
        check("idle_out", {busy, done, div_by_zero, hi, lo}, '0);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'd3, 32'd7, 32'd0);
        check("divu_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0);

        // MTHI then MTLO back to back
        @(negedge CLK);
        start = 1'b1; op = 3'd4; rs_data = 32'h1234;
        @(negedge CLK);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        op = 3'd5; rs_data = 32'h5678;
        @(negedge CLK);
        start = 1'b0;
        check("mt_busy", {62'd0, busy, done}, 64'd0);
        exp_hi = 32'h1234;
        exp_lo = 32'h5678;
        check("mthi_mtlo", {hi, lo}, 64'h0000_1234_0000_5678);

        // flush wins over start in IDLE; reserved op is a no-op
        start = 1'b1; op = 3'd4; rs_data = 32'hDEAD; flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0; op = 3'd6;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        check("idle_flush_resv", {busy, hi, lo}, {1'b0, exp_hi, exp_lo});

        // MTHI during running MULT is dropped
        a = $urandom; b = $urandom;
        e = model(3'd0, a, b);
        start = 1'b1; op = 3'd0; rs_data = a; rt_data = b;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        start = 1'b1; op = 3'd4; rs_data = 32'hCAFE;
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        check("mthi_ignored", {hi, lo}, e);
        check("mthi_ignored_done", {63'd0, done}, 64'd1);

        // flush at RUN cycle 10
        @(negedge CLK);
        start = 1'b1; op = 3'd1; rs_data = $urandom; rt_data = $urandom;
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            saw_done = saw_done | done | busy;
        end
        check("flush_no_done", {63'd0, saw_done}, 64'd0);
        check("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
        run_op(3'd2, 32'd1000, 32'hFFFF_FFF9);

        // asynchronous reset at RUN cycle 20
        @(negedge CLK);
        start = 1'b1; op = 3'd2; rs_data = $urandom; rt_data = $urandom;
        @(negedge CLK);
        start = 1'b0;
        repeat (19) @(negedge CLK);
        #2 RST = 1'b0;
        #1 check("async_rst", {busy, done, div_by_zero, hi, lo}, '0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge CLK);
        RST = 1'b1;
        run_op(3'd2, 32'hFFFF_FF00, 32'd7);

        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(o, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
